alu_issue: RTL and testbench

Execute-stage issue sequencer sitting between the decoder and the ALU. It accepts one decoded LEGv8 instruction with its register operands via a valid/ready handshake, derives the 4-bit ALU control code, and selects and registers operands. It then waits out the ALU's registered one-cycle latency, captures result and flags, and presents them downstream with a second valid/ready handshake, tagged with the destination register and memory-op class.

---
 rtl/alu_issue_if.sv | 44 ++++
 rtl/alu_issue.sv | 154 +++++++++++++++
 tb/tb_alu_issue.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
`default_nettype none
// alu_issue_if: decoder-side, ALU-side and consumer-side signals of the issue sequencer.
// slave is the sequencer's view; master is the surrounding environment's view.
interface alu_issue_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [DATA_W-1:0] in_rn_data;
  logic [DATA_W-1:0] in_rm_data;

  logic [DATA_W-1:0] alu_in_one;
  logic [DATA_W-1:0] alu_in_two;
  logic [3:0]        alu_opcode;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              alu_carry;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [REG_W-1:0]  out_rd;
  logic              out_carry;
  logic              out_branch_taken;
  logic [1:0]        out_mem_op;
  logic              out_illegal;

  modport slave (
    input  in_valid, in_instr, in_rn_data, in_rm_data,
    input  alu_result, alu_zero, alu_carry, out_ready,
    output in_ready, alu_in_one, alu_in_two, alu_opcode,
    output out_valid, out_result, out_rd, out_carry, out_branch_taken, out_mem_op, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_rn_data, in_rm_data,
    output alu_result, alu_zero, alu_carry, out_ready,
    input  in_ready, alu_in_one, alu_in_two, alu_opcode,
    input  out_valid, out_result, out_rd, out_carry, out_branch_taken, out_mem_op, out_illegal
  );
endinterface
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// alu_issue: LEGv8 execute-stage issue sequencer (decode, operand select, ALU wait, result hold).
// Optional feature macro ALU_ISSUE_BYPASS_EN forwards the held result into the next accepted operands.
module alu_issue #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic       clock,
  input  logic       reset_n,
  alu_issue_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_CAPT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [3:0]        r_code;
  logic [REG_W-1:0]  r_rd_p;
  logic [1:0]        r_mem_p;
  logic              r_ill_p;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_result;
  logic [REG_W-1:0]  r_out_rd;
  logic              r_out_carry;
  logic              r_out_br;
  logic [1:0]        r_out_mem;
  logic              r_out_ill;

  logic [10:0]       w_op11;
  logic              w_add, w_sub, w_and, w_orr, w_eor, w_ldur, w_stur;
  logic              w_cbz, w_addi, w_movz, w_rtype, w_ill;
  logic [3:0]        w_code;
  logic [1:0]        w_mem;
  logic [DATA_W-1:0] w_a, w_b, w_op_a, w_op_b;
  logic              w_in_ready, w_accept;

  assign w_op11  = bus.in_instr[31:21];
  assign w_add   = (w_op11 == 11'b10001011000);
  assign w_sub   = (w_op11 == 11'b11001011000);
  assign w_and   = (w_op11 == 11'b10001010000);
  assign w_orr   = (w_op11 == 11'b10101010000);
  assign w_eor   = (w_op11 == 11'b11001010000);
  assign w_ldur  = (w_op11 == 11'b11111000010);
  assign w_stur  = (w_op11 == 11'b11111000000);
  assign w_cbz   = (bus.in_instr[31:24] == 8'b10110100);
  assign w_addi  = (bus.in_instr[31:22] == 10'b1001000100);
  // MOVZ is only legal with hw == 00, so the shift field is part of the match
  assign w_movz  = (w_op11 == 11'b11010010100);
  assign w_rtype = w_add | w_sub | w_and | w_orr | w_eor;
  assign w_ill   = ~(w_rtype | w_ldur | w_stur | w_cbz | w_addi | w_movz);
  assign w_mem   = {w_stur, w_ldur};

  always_comb begin
    w_code = 4'b0000;
    if (w_add | w_ldur | w_stur | w_addi) w_code = 4'b0010;
    else if (w_sub)                       w_code = 4'b1010;
    else if (w_and)                       w_code = 4'b0110;
    else if (w_orr)                       w_code = 4'b0100;
    else if (w_eor)                       w_code = 4'b1001;
    else if (w_cbz)                       w_code = 4'b0111;
    else if (w_movz)                      w_code = 4'b1101;
  end

  assign w_a = w_movz ? {{(DATA_W-16){1'b0}}, bus.in_instr[20:5]} : bus.in_rn_data;
  assign w_b = (w_ldur | w_stur) ? {{(DATA_W-9){bus.in_instr[20]}}, bus.in_instr[20:12]} :
               w_addi            ? {{(DATA_W-12){1'b0}}, bus.in_instr[21:10]}            :
                                   bus.in_rm_data;

`ifdef ALU_ISSUE_BYPASS_EN
  logic             w_fwd_ok;
  logic [REG_W-1:0] w_rn_idx, w_rm_idx;

  // Accepts only happen in IDLE or HOLD, so HOLD is the only state with a live producer
  assign w_fwd_ok = (r_state == S_HOLD) && !r_out_ill && (r_out_mem != 2'b01) &&
                    (r_out_rd != REG_W'(31));
  assign w_rn_idx = REG_W'(bus.in_instr[9:5]);
  assign w_rm_idx = w_cbz ? REG_W'(bus.in_instr[4:0]) : REG_W'(bus.in_instr[20:16]);
  assign w_op_a   = (w_fwd_ok && !w_movz && (r_out_rd == w_rn_idx)) ? r_out_result : w_a;
  assign w_op_b   = (w_fwd_ok && (w_rtype | w_cbz) && (r_out_rd == w_rm_idx)) ? r_out_result : w_b;
`else
  assign w_op_a = w_a;
  assign w_op_b = w_b;
`endif

  assign w_in_ready = (r_state == S_IDLE) || ((r_state == S_HOLD) && bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_code       <= 4'b0000;
      r_rd_p       <= '0;
      r_mem_p      <= 2'b00;
      r_ill_p      <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_rd     <= '0;
      r_out_carry  <= 1'b0;
      r_out_br     <= 1'b0;
      r_out_mem    <= 2'b00;
      r_out_ill    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_alu_a <= w_op_a;
        r_alu_b <= w_op_b;
        r_code  <= w_code;
        r_rd_p  <= REG_W'(bus.in_instr[4:0]);
        r_mem_p <= w_mem;
        r_ill_p <= w_ill;
      end
      case (r_state)
        S_IDLE: if (w_accept) r_state <= S_EXEC;
        S_EXEC: r_state <= S_CAPT;
        S_CAPT: begin
          r_out_valid  <= 1'b1;
          r_out_result <= r_ill_p ? '0 : bus.alu_result;
          r_out_carry  <= bus.alu_carry && ((r_code == 4'b0010) || (r_code == 4'b1010));
          r_out_br     <= (r_code == 4'b0111) && bus.alu_zero;
          r_out_rd     <= r_rd_p;
          r_out_mem    <= r_mem_p;
          r_out_ill    <= r_ill_p;
          r_state      <= S_HOLD;
        end
        S_HOLD: if (bus.out_ready) begin
          r_out_valid <= 1'b0;
          r_state     <= w_accept ? S_EXEC : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready         = w_in_ready;
  assign bus.alu_in_one       = r_alu_a;
  assign bus.alu_in_two       = r_alu_b;
  assign bus.alu_opcode       = r_code;
  assign bus.out_valid        = r_out_valid;
  assign bus.out_result       = r_out_result;
  assign bus.out_rd           = r_out_rd;
  assign bus.out_carry        = r_out_carry;
  assign bus.out_branch_taken = r_out_br;
  assign bus.out_mem_op       = r_out_mem;
  assign bus.out_illegal      = r_out_ill;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// tb_alu_issue: scoreboard bench for alu_issue with a behavioural registered ALU.
// Honours ALU_ISSUE_BYPASS_EN when defined.
module tb_alu_issue;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  code;
    logic [4:0]  rd;
    logic [1:0]  mem;
    logic        carry;
    logic        br;
    logic        ill;
  } exp_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   n_push  = 0;
  int   n_out   = 0;
  int   cyc     = 0;
  int   acc_cyc = 0;
  int   pop_cyc = -1;
  exp_t q[$];
  exp_t last_e;
  exp_t m_e;

  alu_issue_if #(.DATA_W(32), .REG_W(5)) bus ();

  alu_issue #(.DATA_W(32), .REG_W(5)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural ALU: registered result/carry, combinational zero on operand 2
  logic [32:0] w_sum, w_dif;
  assign w_sum        = {1'b0, bus.alu_in_one} + {1'b0, bus.alu_in_two};
  assign w_dif        = {1'b0, bus.alu_in_one} + {1'b0, ~bus.alu_in_two} + 33'd1;
  assign bus.alu_zero = (bus.alu_in_two == 32'd0);
  always @(posedge clock) begin
    case (bus.alu_opcode)
      4'b0010: begin bus.alu_result <= w_sum[31:0]; bus.alu_carry <= w_sum[32]; end
      4'b1010: begin bus.alu_result <= w_dif[31:0]; bus.alu_carry <= w_dif[32]; end
      4'b0100: begin bus.alu_result <= bus.alu_in_one | bus.alu_in_two; bus.alu_carry <= 1'b1; end
      4'b1001: begin bus.alu_result <= bus.alu_in_one ^ bus.alu_in_two; bus.alu_carry <= 1'b1; end
      4'b0111: begin bus.alu_result <= bus.alu_in_two; bus.alu_carry <= 1'b1; end
      4'b1101: begin bus.alu_result <= bus.alu_in_one; bus.alu_carry <= 1'b1; end
      default: begin bus.alu_result <= bus.alu_in_one & bus.alu_in_two; bus.alu_carry <= 1'b1; end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic is_rt(input logic [31:0] ins);
    return ins[31:21] inside {11'b10001011000, 11'b11001011000, 11'b10001010000,
                              11'b10101010000, 11'b11001010000};
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rn, input logic [31:0] rm);
    exp_t e;
    e = '0;
    e.a  = rn;
    e.b  = rm;
    e.rd = ins[4:0];
    if      (ins[31:21] == 11'b10001011000) e.code = 4'b0010;
    else if (ins[31:21] == 11'b11001011000) e.code = 4'b1010;
    else if (ins[31:21] == 11'b10001010000) e.code = 4'b0110;
    else if (ins[31:21] == 11'b10101010000) e.code = 4'b0100;
    else if (ins[31:21] == 11'b11001010000) e.code = 4'b1001;
    else if (ins[31:21] == 11'b11111000010) begin e.code = 4'b0010; e.mem = 2'b01; e.b = {{23{ins[20]}}, ins[20:12]}; end
    else if (ins[31:21] == 11'b11111000000) begin e.code = 4'b0010; e.mem = 2'b10; e.b = {{23{ins[20]}}, ins[20:12]}; end
    else if (ins[31:24] == 8'hB4)           e.code = 4'b0111;
    else if (ins[31:22] == 10'b1001000100)  begin e.code = 4'b0010; e.b = {20'd0, ins[21:10]}; end
    else if (ins[31:21] == 11'b11010010100) begin e.code = 4'b1101; e.a = {16'd0, ins[20:5]}; end
    else e.ill = 1'b1;
    case (e.code)
      4'b0010: {e.carry, e.res} = {1'b0, e.a} + {1'b0, e.b};
      4'b1010: begin e.res = e.a - e.b; e.carry = (e.a >= e.b); end
      4'b0110: e.res = e.a & e.b;
      4'b0100: e.res = e.a | e.b;
      4'b1001: e.res = e.a ^ e.b;
      4'b0111: begin e.res = e.b; e.br = (e.b == 32'd0); end
      4'b1101: e.res = e.a;
      default: e.res = 32'd0;
    endcase
    return e;
  endfunction

  // Offer one instruction; expectation is queued at the accepting edge
  task automatic send(input logic [31:0] ins, input logic [31:0] rn, input logic [31:0] rm);
    int          n;
    logic [31:0] frn, frm;
    exp_t        e;
    bus.in_instr   = ins;
    bus.in_rn_data = rn;
    bus.in_rm_data = rm;
    bus.in_valid   = 1'b1;
    n = 0;
    @(negedge clock);
    while (!bus.in_ready && n < 50) begin n++; @(negedge clock); end
    if (!bus.in_ready) check("accept_timeout", 32'd0, 32'd1);
    else begin
      frn = rn;
      frm = rm;
`ifdef ALU_ISSUE_BYPASS_EN
      if (((n_out < n_push) || (pop_cyc == cyc)) && !last_e.ill && last_e.mem != 2'b01 && last_e.rd != 5'd31) begin
        if (last_e.rd == ins[9:5]) frn = last_e.res;
        if (is_rt(ins) && last_e.rd == ins[20:16]) frm = last_e.res;
        if (ins[31:24] == 8'hB4 && last_e.rd == ins[4:0]) frm = last_e.res;
      end
`endif
      e = model(ins, frn, frm);
      q.push_back(e);
      last_e = e;
      n_push++;
      @(posedge clock);
      #1 acc_cyc = cyc;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while (q.size() != 0 && n < 100) begin n++; @(negedge clock); end
    check("drain", q.size(), 0);
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (reset_n && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
      else begin
        m_e = q.pop_front();
        check("result",  bus.out_result,       m_e.res);
        check("rd",      bus.out_rd,           m_e.rd);
        check("carry",   bus.out_carry,        m_e.carry);
        check("branch",  bus.out_branch_taken, m_e.br);
        check("mem_op",  bus.out_mem_op,       m_e.mem);
        check("illegal", bus.out_illegal,      m_e.ill);
        check("alu_one", bus.alu_in_one,       m_e.a);
        check("alu_two", bus.alu_in_two,       m_e.b);
        check("opcode",  bus.alu_opcode,       m_e.code);
      end
      n_out++;
      pop_cyc = cyc;
    end
  end

  logic [31:0] t_ins [13];
  logic [31:0] t_rn  [4];
  logic [31:0] t_rm  [4];

  initial begin
    int   prev, n;
    exp_t ea;
    logic [31:0] rn, rm;
    t_ins = '{32'h8B020023, 32'hF85F8024, 32'hB4000005, 32'hB4000005, 32'h00000000,
              {11'b11001011000, 5'd2, 6'd0, 5'd1, 5'd5},
              {11'b10001010000, 5'd4, 6'd0, 5'd6, 5'd7},
              {11'b10101010000, 5'd8, 6'd0, 5'd9, 5'd10},
              {11'b11001010000, 5'd11, 6'd0, 5'd12, 5'd13},
              {11'b11111000000, 9'h004, 2'b00, 5'd2, 5'd9},
              {10'b1001000100, 12'h7FF, 5'd1, 5'd10},
              {9'b110100101, 2'b00, 16'hBEEF, 5'd11},
              {9'b110100101, 2'b01, 16'h1234, 5'd12}};
    t_rn = '{32'hFFFFFFFF, 32'h00000100, 32'h0, 32'h0};
    t_rm = '{32'h00000001, 32'h0, 32'h0, 32'h7};
    last_e         = '0;
    bus.in_valid   = 1'b0;
    bus.in_instr   = 32'd0;
    bus.in_rn_data = 32'd0;
    bus.in_rm_data = 32'd0;
    bus.out_ready  = 1'b1;

    repeat (3) @(negedge clock);
    check("rst_in_ready",  bus.in_ready,         1);
    check("rst_out_valid", bus.out_valid,        0);
    check("rst_result",    bus.out_result,       0);
    check("rst_rd",        bus.out_rd,           0);
    check("rst_flags",     {bus.out_carry, bus.out_branch_taken, bus.out_mem_op, bus.out_illegal}, 0);
    check("rst_alu",       bus.alu_in_one | bus.alu_in_two | {28'd0, bus.alu_opcode}, 0);
    @(posedge clock);
    #1 reset_n = 1'b1;

    // Directed table with out_ready high: also checks one accept per three cycles
    prev = 0;
    for (int i = 0; i < 13; i++) begin
      rn = (i < 4) ? t_rn[i] : $urandom();
      rm = (i < 4) ? t_rm[i] : $urandom();
      send(t_ins[i], rn, rm);
      if (i > 0) check("thruput", acc_cyc - prev, 3);
      prev = acc_cyc;
    end
    drain();

    // Random mix under random backpressure
    n = 1;
    fork
      begin
        while (n != 0) begin @(posedge clock); #1 bus.out_ready = ($urandom_range(0, 3) != 0); end
      end
      begin
        for (int i = 0; i < 24; i++) send(t_ins[$urandom_range(0, 12)], $urandom(), $urandom());
        n = 0;
      end
    join
    drain();

    // Stall in HOLD for four cycles, then both handshakes on one edge
    bus.out_ready = 1'b0;
    ea = model(32'h8B020023, 32'd10, 32'd20);
    send(32'h8B020023, 32'd10, 32'd20);
    n = 0;
    @(negedge clock);
    while (!bus.out_valid && n < 20) begin n++; @(negedge clock); end
    check("hold_valid", bus.out_valid, 1);
    bus.in_instr = 32'hCB030064;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("stall_in_ready", bus.in_ready,   0);
      check("stall_valid",    bus.out_valid,  1);
      check("stall_result",   bus.out_result, ea.res);
      @(negedge clock);
    end
    @(posedge clock);
    #1 bus.out_ready = 1'b1;
    send(32'hCB030064, 32'd7, 32'd3);
    check("same_edge", acc_cyc, pop_cyc + 1);
    @(negedge clock);
    check("exec_valid_low", bus.out_valid, 0);
    drain();

    // Forwarding scenario: SUB X4 = X3 - X3 right behind ADD X3 = 5
    bus.out_ready = 1'b0;
    send({11'b10001011000, 5'd2, 6'd0, 5'd1, 5'd3}, 32'd2, 32'd3);
    n = 0;
    @(negedge clock);
    while (!bus.out_valid && n < 20) begin n++; @(negedge clock); end
    @(posedge clock);
    #1 bus.out_ready = 1'b1;
    send(32'hCB030064, 32'd0, 32'd0);
    @(negedge clock);
`ifdef ALU_ISSUE_BYPASS_EN
    check("byp_in_one", bus.alu_in_one, 32'd5);
    check("byp_in_two", bus.alu_in_two, 32'd5);
`else
    check("nobyp_in_one", bus.alu_in_one, 32'd0);
    check("nobyp_in_two", bus.alu_in_two, 32'd0);
`endif
    drain();

    // Asynchronous reset while EXEC: op is discarded
    bus.in_instr   = 32'h8B020023;
    bus.in_rn_data = 32'd1;
    bus.in_rm_data = 32'd2;
    bus.in_valid   = 1'b1;
    @(negedge clock);
    check("idle_ready", bus.in_ready, 1);
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("arst_in_ready",  bus.in_ready,   1);
    check("arst_out_valid", bus.out_valid,  0);
    check("arst_result",    bus.out_result, 0);
    check("arst_alu",       bus.alu_in_one | bus.alu_in_two | {28'd0, bus.alu_opcode}, 0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    n = 0;
    repeat (6) begin @(negedge clock); if (bus.out_valid) n++; end
    check("post_rst_valid", n, 0);
    check("op_count", n_out, n_push);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
